// File: rtl/unsat_clause_picker_ctrl.sv
// rtl/unsat_clause_picker_ctrl.sv - random unsatisfied-clause picker using a time-multiplexed pairwise tournament
//
// compare_two_checker: combinational pairwise clause selector.
//   clause1_index/clause1_sat, clause2_index/clause2_sat : the two contenders
//   in_setting                                         : tie-break bit (0 -> clause 1, 1 -> clause 2)
//   winner_index/winner_sat                            : chosen clause, sat = AND of both flags
//
// unsat_clause_picker_ctrl: latches N = 2^W clause-satisfied flags on in_start and reduces
// them one pair per cycle through a single compare_two_checker, tie-breaking with an LFSR.
//   in_clk, in_reset_n          : clock, synchronous active-low reset
//   in_start                    : request pulse, only honoured when idle
//   in_clauses_satisfied[N-1:0] : bit i set when clause i is satisfied
//   out_busy                    : high while reducing and in the done cycle
//   out_done                    : one-cycle pulse, result valid
//   out_clause_index[W-1:0]     : chosen clause
//   out_all_satisfied           : 1 only when every clause was satisfied

module compare_two_checker #(
    parameter int W = 3
) (
    input  logic [W-1:0] clause1_index,
    input  logic         clause1_sat,
    input  logic [W-1:0] clause2_index,
    input  logic         clause2_sat,
    input  logic         in_setting,
    output logic [W-1:0] winner_index,
    output logic         winner_sat
);
    logic pick_second;

    // When the flags differ the unsatisfied one wins; clause1_sat = 1 then means clause 2 is the unsatisfied one.
    assign pick_second  = (clause1_sat != clause2_sat) ? clause1_sat : in_setting;
    assign winner_index = pick_second ? clause2_index : clause1_index;
    assign winner_sat   = clause1_sat & clause2_sat;
endmodule

module unsat_clause_picker_ctrl #(
    parameter int          MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
    parameter logic [15:0] LFSR_SEED                          = 16'hACE1
) (
    input  logic                                          in_clk,
    input  logic                                          in_reset_n,
    input  logic                                          in_start,
    input  logic [(1 << MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] in_clauses_satisfied,
    output logic                                          out_busy,
    output logic                                          out_done,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
    output logic                                          out_all_satisfied
);
    localparam int W = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int N = 1 << W;
    // An all-zero Galois LFSR never leaves zero, so a zero seed falls back to the default.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   slot_index [N];
    logic [N-1:0]   slot_sat;
    logic [W-1:0]   pair;
    logic [W:0]     count;
    logic [15:0]    lfsr;

    logic [W-1:0]   lo_sel;
    logic [W-1:0]   hi_sel;
    logic [W:0]     half;
    logic           last_pair;
    logic [15:0]    lfsr_next;
    logic [W-1:0]   win_index;
    logic           win_sat;

    assign lo_sel    = pair << 1;
    assign hi_sel    = lo_sel | W'(1);
    assign half      = count >> 1;
    assign last_pair = ({1'b0, pair} == (half - (W+1)'(1)));
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    compare_two_checker #(
        .W(W)
    ) u_cmp (
        .clause1_index (slot_index[lo_sel]),
        .clause1_sat   (slot_sat[lo_sel]),
        .clause2_index (slot_index[hi_sel]),
        .clause2_sat   (slot_sat[hi_sel]),
        .in_setting    (lfsr[0]),
        .winner_index  (win_index),
        .winner_sat    (win_sat)
    );

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            state             <= IDLE;
            count             <= '0;
            pair              <= '0;
            out_busy          <= 1'b0;
            out_done          <= 1'b0;
            out_clause_index  <= '0;
            out_all_satisfied <= 1'b0;
            lfsr              <= SEED_EFF;
        end else begin
            case (state)
                IDLE: begin
                    if (in_start) begin
                        for (int i = 0; i < N; i++) begin
                            slot_index[i] <= W'(i);
                        end
                        slot_sat <= in_clauses_satisfied;
                        count    <= (W+1)'(N);
                        pair     <= '0;
                        out_busy <= 1'b1;
                        state    <= REDUCE;
                    end
                end
                REDUCE: begin
                    // Writing the winner back to slot[pair] is safe: this level only reads slots above pair from now on.
                    slot_index[pair] <= win_index;
                    slot_sat[pair]   <= win_sat;
                    lfsr             <= lfsr_next;
                    if (last_pair) begin
                        count <= half;
                        pair  <= '0;
                        if (count == (W+1)'(2)) begin
                            out_clause_index  <= win_index;
                            out_all_satisfied <= win_sat;
                            out_done          <= 1'b1;
                            state             <= DONE;
                        end
                    end else begin
                        pair <= pair + W'(1);
                    end
                end
                DONE: begin
                    out_done <= 1'b0;
                    out_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unsat_clause_picker_ctrl.sv
// tb/tb_unsat_clause_picker_ctrl.sv - randomized self-checking bench against a queue-based tournament model

module tb_unsat_clause_picker_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] flags;
    logic       busy, done, sat;
    logic [2:0] idx;
    logic       busy_z, done_z, sat_z;
    logic [2:0] idx_z;
    logic       start1;
    logic [1:0] flags1;
    logic       busy1, done1, sat1;
    logic [0:0] idx1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] m_lfsr  = 16'hACE1;
    logic [15:0] m_lfsr1 = 16'hACE1;

    always #5 clk = ~clk;

    unsat_clause_picker_ctrl #(.MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(3), .LFSR_SEED(16'hACE1)) u_dut (
        .in_clk(clk), .in_reset_n(reset_n), .in_start(start), .in_clauses_satisfied(flags),
        .out_busy(busy), .out_done(done), .out_clause_index(idx), .out_all_satisfied(sat));

    unsat_clause_picker_ctrl #(.MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(3), .LFSR_SEED(16'h0000)) u_zero (
        .in_clk(clk), .in_reset_n(reset_n), .in_start(start), .in_clauses_satisfied(flags),
        .out_busy(busy_z), .out_done(done_z), .out_clause_index(idx_z), .out_all_satisfied(sat_z));

    unsat_clause_picker_ctrl #(.MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(1), .LFSR_SEED(16'hACE1)) u_min (
        .in_clk(clk), .in_reset_n(reset_n), .in_start(start1), .in_clauses_satisfied(flags1),
        .out_busy(busy1), .out_done(done1), .out_clause_index(idx1), .out_all_satisfied(sat1));

    // Tournament model: candidates reduced level by level; each pairing consumes one LFSR bit.
    task automatic model_pick(input logic [7:0] f, input int n, inout logic [15:0] l,
                              output int wi, output bit ws);
        int cand_i[$];
        bit cand_s[$];
        for (int i = 0; i < n; i++) begin
            cand_i.push_back(i);
            cand_s.push_back(f[i]);
        end
        while (cand_i.size() > 1) begin
            int nxt_i[$];
            bit nxt_s[$];
            for (int p = 0; p < cand_i.size() / 2; p++) begin
                bit tie = l[0];
                int a = 2 * p;
                int b = 2 * p + 1;
                int w;
                l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
                if (cand_s[a] && !cand_s[b])      w = b;
                else if (!cand_s[a] && cand_s[b]) w = a;
                else                              w = tie ? b : a;
                nxt_i.push_back(cand_i[w]);
                nxt_s.push_back(cand_s[a] & cand_s[b]);
            end
            cand_i = nxt_i;
            cand_s = nxt_s;
        end
        wi = cand_i[0];
        ws = cand_s[0];
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || busy1) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    // Issues one request to the W=3 pair and captures what it produced (lat = -1 if no done).
    task automatic run_op(input logic [7:0] f, output int lat, output logic [2:0] ri, output logic rs,
                          output logic [2:0] rzi, output logic rzs, output logic zdone);
        wait_idle();
        @(negedge clk);
        flags = f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; ri = '0; rs = 1'b0; rzi = '0; rzs = 1'b0; zdone = 1'b0;
        for (int j = 0; j < 30; j++) begin
            if (done) begin
                lat = j; ri = idx; rs = sat; rzi = idx_z; rzs = sat_z; zdone = done_z;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; flags = '0; start1 = 1'b0; flags1 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, idx, sat} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_main: got busy=%b done=%b idx=%0d sat=%b, want all 0", busy, done, idx, sat);
        end
        n_checks++;
        if ({busy_z, done_z, idx_z, sat_z, busy1, done1, idx1, sat1} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_others: got zero=%b%b%0d%b min=%b%b%0d%b, want all 0",
                     busy_z, done_z, idx_z, sat_z, busy1, done1, idx1, sat1);
        end
        reset_n = 1'b1;
        m_lfsr = 16'hACE1; m_lfsr1 = 16'hACE1;
    endtask

    task automatic test_single_unsat();
        int ei; bit es;
        int dones = 0;
        model_pick(8'hDF, 8, m_lfsr, ei, es);
        wait_idle();
        @(negedge clk);
        flags = 8'hDF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            n_checks++;
            if (busy !== (j <= 7) || done !== (j == 7)) begin
                n_fail++;
                $display("FAIL single_timing cycle k+%0d: got busy=%b done=%b, want busy=%b done=%b",
                         j + 1, busy, done, (j <= 7), (j == 7));
            end
            if (done) begin
                dones++;
                n_checks++;
                if (idx !== 3'd5 || sat !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_result: got idx=%0d sat=%b, want idx=5 sat=0", idx, sat);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL single_done_count: got %0d, want 1", dones);
        end
    endtask

    task automatic test_all_satisfied();
        int lat, ei; bit es; logic [2:0] ri, rzi; logic rs, rzs, zd;
        model_pick(8'hFF, 8, m_lfsr, ei, es);
        run_op(8'hFF, lat, ri, rs, rzi, rzs, zd);
        n_checks++;
        if (lat != 7 || ri !== 3'(ei) || rs !== 1'b1) begin
            n_fail++;
            $display("FAIL all_sat: got lat=%0d idx=%0d sat=%b, want lat=7 idx=%0d sat=1", lat, ri, rs, ei);
        end
    endtask

    task automatic test_random_selection();
        int hist[8];
        int lat, ei; bit es; logic [2:0] ri, rzi; logic rs, rzs, zd;
        int bad = 0;
        for (int i = 0; i < 8; i++) hist[i] = 0;
        for (int r = 0; r < 4000; r++) begin
            model_pick(8'h00, 8, m_lfsr, ei, es);
            run_op(8'h00, lat, ri, rs, rzi, rzs, zd);
            n_checks++;
            if (lat != 7 || ri !== 3'(ei) || rs !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_sel #%0d: got lat=%0d idx=%0d sat=%b, want lat=7 idx=%0d sat=0",
                             r, lat, ri, rs, ei);
            end
            hist[ri]++;
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (hist[i] < 425 || hist[i] > 575) begin
                n_fail++;
                $display("FAIL random_hist[%0d]: got %0d, want 425..575", i, hist[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, ei; bit es; logic [2:0] ri, rzi; logic rs, rzs, zd;
        int dones = 0;
        wait_idle();
        @(negedge clk);
        flags = 8'($urandom); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_busy: got busy=%b done=%b, want 1 0", busy, done);
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_lfsr = 16'hACE1; m_lfsr1 = 16'hACE1;
        n_checks++;
        if ({busy, done, idx, sat, busy_z, done_z, idx_z, sat_z} !== 12'b0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs: got %b%b%0d%b / %b%b%0d%b, want all 0",
                     busy, done, idx, sat, busy_z, done_z, idx_z, sat_z);
        end
        repeat (12) begin
            @(posedge clk); #1;
            if (done || done_z) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL midop_no_done: got %0d done pulses, want 0", dones);
        end
        flags = 8'($urandom);
        model_pick(flags, 8, m_lfsr, ei, es);
        run_op(flags, lat, ri, rs, rzi, rzs, zd);
        n_checks++;
        if (lat != 7 || ri !== 3'(ei) || rs !== es) begin
            n_fail++;
            $display("FAIL midop_restart: got lat=%0d idx=%0d sat=%b, want lat=7 idx=%0d sat=%b",
                     lat, ri, rs, ei, es);
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] f;
        int ei; bit es;
        int dones = 0;
        logic [2:0] got_i = '0;
        logic got_s = 1'b0;
        f = 8'($urandom);
        model_pick(f, 8, m_lfsr, ei, es);
        wait_idle();
        @(negedge clk);
        flags = f; start = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j <= 8; j++) begin
            if (done) begin
                dones++; got_i = idx; got_s = sat;
            end
            @(negedge clk);
            flags = 8'($urandom);
            start = (j < 8);
            @(posedge clk); #1;
        end
        repeat (12) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ignored_start_count: got %0d done pulses, want 1", dones);
        end
        n_checks++;
        if (got_i !== 3'(ei) || got_s !== es) begin
            n_fail++;
            $display("FAIL ignored_start_result: got idx=%0d sat=%b, want idx=%0d sat=%b", got_i, got_s, ei, es);
        end
    endtask

    task automatic test_zero_seed();
        int lat, ei; bit es; logic [2:0] ri, rzi; logic rs, rzs, zd;
        logic [7:0] f;
        for (int r = 0; r < 40; r++) begin
            f = 8'($urandom);
            model_pick(f, 8, m_lfsr, ei, es);
            run_op(f, lat, ri, rs, rzi, rzs, zd);
            n_checks++;
            if (zd !== 1'b1 || rzi !== 3'(ei) || rzs !== es || ri !== 3'(ei) || rs !== es) begin
                n_fail++;
                $display("FAIL zero_seed #%0d flags=%h: got zero idx=%0d sat=%b done=%b main idx=%0d sat=%b, want idx=%0d sat=%b",
                         r, f, rzi, rzs, zd, ri, rs, ei, es);
            end
        end
    endtask

    task automatic test_min_size();
        int ei; bit es;
        logic [1:0] f;
        for (int r = 0; r < 12; r++) begin
            f = 2'($urandom);
            model_pick({6'b0, f}, 2, m_lfsr1, ei, es);
            wait_idle();
            @(negedge clk);
            flags1 = f; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            n_checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL min_reduce #%0d: got busy=%b done=%b, want 1 0", r, busy1, done1);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done1 !== 1'b1 || idx1 !== 1'(ei) || sat1 !== es) begin
                n_fail++;
                $display("FAIL min_done #%0d flags=%b: got done=%b idx=%0d sat=%b, want done=1 idx=%0d sat=%b",
                         r, f, done1, idx1, sat1, ei, es);
            end
            @(posedge clk); #1;
            n_checks++;
            if (busy1 !== 1'b0 || done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL min_idle #%0d: got busy=%b done=%b, want 0 0", r, busy1, done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_unsat();
        test_all_satisfied();
        test_reset_mid_op();
        test_ignored_start();
        test_zero_seed();
        test_min_size();
        test_random_selection();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
